// File: rtl/skid_buf_pkg.sv
// Shared types and constants for the skid_buf_rst register slice.
package skid_buf_pkg;

    localparam int unsigned STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_stall_cnt.sv
// Saturating count of cycles where downstream holds off a valid payload.
module skid_stall_cnt
    import skid_buf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic [STALL_CNT_W-1:0] o_cnt
);

    logic [STALL_CNT_W-1:0] r_cnt;

    // Holds at all-ones once saturated; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/skid_buf_rst.sv
// Two-entry skid buffer with fully registered valid/ready/data and a sync flush.
// Optional stall counter enabled by defining SKID_BUF_STALL_CNT_EN.
module skid_buf_rst
    import skid_buf_pkg::*;
#(
    parameter int unsigned       WIDTH       = 64,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef SKID_BUF_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_out_valid_nxt;
    logic             w_in_ready_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_in_xfer  = in_valid  & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= RESET_VALUE;
            r_skid      <= RESET_VALUE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    // Handshake flags are precomputed from the next state so they leave a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        unique case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_main_nxt  = in_data;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = in_data;
                end else if (w_in_xfer) begin
                    w_skid_nxt  = in_data;
                    w_state_nxt = FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase

        if (clr) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = RESET_VALUE;
            w_skid_nxt  = RESET_VALUE;
        end

        w_out_valid_nxt = (w_state_nxt != EMPTY);
        w_in_ready_nxt  = (w_state_nxt != FULL);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

`ifdef SKID_BUF_STALL_CNT_EN
    logic w_stall;

    assign w_stall = r_out_valid & ~out_ready;

    skid_stall_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_inc (w_stall),
        .o_cnt (stall_cnt)
    );
`endif

endmodule

// File: doc/skid_buf_rst.md
SKID_BUF_RST -- requirements
Module: skid_buf_rst

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits.
REQ-002 Parameter RESET_VALUE, default 0, value driven on out_data after reset and after clr.
REQ-003 clk  input  1  single clock, all state updated on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous flush, active-high.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  upstream may transfer; registered, not combinationally dependent on out_ready.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  downstream payload valid; registered.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_data  output  WIDTH  downstream payload; registered.
REQ-012 stall_cnt  output  32  stall cycle count; present only with SKID_BUF_STALL_CNT_EN.

Function
REQ-013 Transfer occurs on an edge where valid and ready are both 1, on either side; no transfer otherwise.
REQ-014 Storage: main register (drives out_data) and one skid register; capacity exactly 2 entries.
REQ-015 States: EMPTY (0 entries), BUSY (main only), FULL (main+skid).
REQ-016 EMPTY: input transfer -> BUSY, data to main; else stay.
REQ-017 BUSY: input and output transfer -> BUSY, new data to main; input only -> FULL, data to skid; output only -> EMPTY; neither -> stay.
REQ-018 FULL: output transfer -> BUSY, skid moved to main; else stay; no input transfer possible.
REQ-019 out_valid = 1 in BUSY and FULL, 0 in EMPTY.
REQ-020 in_ready = 1 in EMPTY and BUSY, 0 in FULL.
REQ-021 Latency: data accepted at edge N appears on out_data with out_valid after edge N when buffer was EMPTY or draining (1 cycle); ordering strictly FIFO.
REQ-022 out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 Zero-bubble: sustained in_valid=out_ready=1 gives one transfer per cycle on both sides.
REQ-024 clr: next state EMPTY, out_valid=0, in_ready=1, out_data=RESET_VALUE, skid discarded; clr wins over simultaneous input/output transfers, and the in_data offered that cycle is dropped.
REQ-025 in_data sampled only on an input transfer; out_ready ignored in EMPTY.

Reset
REQ-026 On rst assertion, immediately: state EMPTY, out_valid=0, in_ready=1, out_data=RESET_VALUE, skid=RESET_VALUE, stall_cnt=0.
REQ-027 Reset mid-operation discards both entries without any output transfer; first edge after deassertion behaves as EMPTY.

Configuration
REQ-028 Macro SKID_BUF_STALL_CNT_EN defined: stall_cnt port exists, increments on each edge with out_valid=1 and out_ready=0, saturates at 0xFFFF_FFFF, zeroed by rst and clr.
REQ-029 Macro undefined: no stall_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-030 Package skid_buf_pkg holds state enum typedef (EMPTY, BUSY, FULL) and constant STALL_CNT_W = 32.
REQ-031 Sub-module skid_stall_cnt holds the saturating counter, instantiated only under SKID_BUF_STALL_CNT_EN.

Verification
REQ-032 rst released, in_data=0xA5 in_valid=1 one cycle, out_ready=1 -> out_valid=1, out_data=0xA5 next cycle, then EMPTY.
REQ-033 out_ready=0, push 0x11 then 0x22 -> in_ready=0 after second edge; third value 0x33 held off; release out_ready -> 0x11, 0x22, 0x33 in order.
REQ-034 100 cycles in_valid=out_ready=1, incrementing data 0..99 -> 100 outputs, in order, no bubbles after first.
REQ-035 FULL with 0x11/0x22, clr with in_valid=1 data 0x44 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VALUE, 0x44 never emitted.
REQ-036 Macro defined: hold out_ready=0 with out_valid=1 for 7 cycles -> stall_cnt=7; force count 0xFFFF_FFFE plus 3 stalls -> 0xFFFF_FFFF.
REQ-037 rst pulsed asynchronously between edges in FULL -> out_valid=0 and in_ready=1 before next edge.
